// File: rtl/rtc_clk1hz_gen_if.sv
// APB slave bundle for the RTC 1 Hz prescaler: the PCLK-domain register port.
interface rtc_clk1hz_gen_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [11:2] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;

    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA);
    modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA);
endinterface

// File: rtl/rtc_clk1hz_gen.sv
// PCLK prescaler producing the RTC 1 Hz clock and a one-cycle tick, with an
// APB-programmable divisor and an optional periodic +/-1 cycle trim.
module rtc_clk1hz_gen #(
    parameter logic [31:0] DEF_DIV = 32'd24_999_999
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    rtc_clk1hz_gen_if.slave   apb,
    output logic              CLK1HZ,
    output logic              TICK1HZ
);
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

    localparam logic [9:0] A_PSDIV  = 10'h000;
    localparam logic [9:0] A_PSCR   = 10'h001;
    localparam logic [9:0] A_PSTRIM = 10'h002;
    localparam logic [9:0] A_PSCNT  = 10'h003;

    state_e      state_q, state_d;
    logic [31:0] psdiv_q, psdiv_d;
    logic [15:0] trimn_q, trimn_d;
    logic        trimsgn_q, trimsgn_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [31:0] div_act_q, div_act_d;
    logic        clk_q, clk_d;
    logic        tick_q, tick_d;

    logic        wr_en, wr_div, wr_cr, wr_trim;
    logic        run_active, trim_due, trim_wrap;
    logic [31:0] dive, term;
    logic [32:0] half;

    assign wr_en   = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign wr_div  = wr_en && (apb.PADDR == A_PSDIV);
    assign wr_cr   = wr_en && (apb.PADDR == A_PSCR);
    assign wr_trim = wr_en && (apb.PADDR == A_PSTRIM);

    always_comb begin
        psdiv_d   = psdiv_q;
        trimn_d   = trimn_q;
        trimsgn_d = trimsgn_q;
        if (wr_div) psdiv_d = apb.PWDATA;
        if (wr_trim) begin
            trimn_d   = apb.PWDATA[15:0];
            trimsgn_d = apb.PWDATA[16];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (wr_cr && apb.PWDATA[0])  state_d = S_RUN;
            S_RUN:   if (wr_cr && !apb.PWDATA[0]) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counting only happens while both the current and next state are RUN, so
    // the enabling write edge leaves cnt at 0 and the disabling edge clears it.
    assign run_active = (state_q == S_RUN) && (state_d == S_RUN);

    always_comb begin
        dive      = (div_act_q == 32'd0) ? 32'd1 : div_act_q;
        trim_due  = (trimn_q != 16'd0) && (tcnt_q == trimn_q - 16'd1);
        trim_wrap = (trimn_q == 16'd0) || (tcnt_q >= trimn_q - 16'd1);
        half      = ({1'b0, dive} + 33'd1) >> 1;
        term      = dive;
        // Lengthening is dropped at the top of the range so TERM cannot wrap.
        if (trim_due) begin
            if (!trimsgn_q && (dive != 32'hFFFF_FFFF)) term = dive + 32'd1;
            else if (trimsgn_q && (dive >= 32'd2))     term = dive - 32'd1;
        end

        cnt_d     = 32'd0;
        tcnt_d    = 16'd0;
        div_act_d = psdiv_q;
        tick_d    = 1'b0;
        clk_d     = 1'b0;
        if (run_active) begin
            if (cnt_q == term) begin
                tcnt_d = trim_wrap ? 16'd0 : tcnt_q + 16'd1;
                tick_d = 1'b1;
            end else begin
                cnt_d     = cnt_q + 32'd1;
                tcnt_d    = tcnt_q;
                div_act_d = div_act_q;
            end
            clk_d = ({1'b0, cnt_d} >= half);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            psdiv_q   <= DEF_DIV;
            trimn_q   <= 16'd0;
            trimsgn_q <= 1'b0;
            cnt_q     <= 32'd0;
            tcnt_q    <= 16'd0;
            div_act_q <= DEF_DIV;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            psdiv_q   <= psdiv_d;
            trimn_q   <= trimn_d;
            trimsgn_q <= trimsgn_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            div_act_q <= div_act_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        apb.PRDATA = 32'd0;
        if (apb.PSEL && !apb.PWRITE) begin
            case (apb.PADDR)
                A_PSDIV:  apb.PRDATA = psdiv_q;
                A_PSCR:   apb.PRDATA = {31'd0, state_q == S_RUN};
                A_PSTRIM: apb.PRDATA = {15'd0, trimsgn_q, trimn_q};
                A_PSCNT:  apb.PRDATA = cnt_q;
                default:  apb.PRDATA = 32'd0;
            endcase
        end
    end

    assign CLK1HZ  = clk_q;
    assign TICK1HZ = tick_q;
endmodule

// File: tb/tb_rtc_clk1hz_gen.sv
// Directed bench for rtc_clk1hz_gen: register access, divide patterns, trim,
// mid-period divisor change and asynchronous reset.
module tb_rtc_clk1hz_gen;
    logic PCLK;
    logic PRESETn;
    logic CLK1HZ;
    logic TICK1HZ;
    int   total = 0;
    int   bad   = 0;

    rtc_clk1hz_gen_if apb ();

    rtc_clk1hz_gen #(.DEF_DIV(32'd24_999_999)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .apb     (apb.slave),
        .CLK1HZ  (CLK1HZ),
        .TICK1HZ (TICK1HZ)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called one step after a rising edge; returns one step after the write edge.
    task automatic apb_wr(input logic [11:0] addr, input logic [31:0] data);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b1;
        apb.PADDR   = addr[11:2];
        apb.PWDATA  = data;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
    endtask

    task automatic apb_rd(input logic [11:0] addr, output logic [31:0] data);
        apb.PSEL   = 1'b1;
        apb.PWRITE = 1'b0;
        apb.PADDR  = addr[11:2];
        #1;
        data = apb.PRDATA;
        apb.PSEL = 1'b0;
    endtask

    // Cycle-by-cycle check of one enable run with period per (PSDIV = per-1).
    task automatic chk_seq(input string tag, input int n, input int per);
        logic [31:0] v;
        for (int i = 0; i < n; i++) begin
            int ph;
            ph = i % per;
            chk({tag, "_clk"}, {31'd0, CLK1HZ}, (ph >= per / 2) ? 32'd1 : 32'd0);
            chk({tag, "_tick"}, {31'd0, TICK1HZ}, (ph == 0 && i != 0) ? 32'd1 : 32'd0);
            apb_rd(12'h00C, v);
            chk({tag, "_cnt"}, v, ph);
            @(posedge PCLK); #1;
        end
    endtask

    // Edges until the next TICK1HZ; -1 when it never comes.
    task automatic wait_tick(output int len);
        len = -1;
        for (int n = 1; n <= 64; n++) begin
            @(posedge PCLK); #1;
            if (TICK1HZ) begin
                len = n;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        int          len;
        int          ticks;
        PRESETn     = 1'b0;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        apb.PWDATA  = '0;
        #23 PRESETn = 1'b1;
        @(posedge PCLK); #1;

        apb_rd(12'h000, v); chk("rst_psdiv", v, 32'd24_999_999);
        apb_rd(12'h004, v); chk("rst_pscr", v, 32'd0);
        apb_rd(12'h008, v); chk("rst_pstrim", v, 32'd0);
        apb_rd(12'h00C, v); chk("rst_pscnt", v, 32'd0);
        chk("rst_clk", {31'd0, CLK1HZ}, 32'd0);
        chk("rst_tick", {31'd0, TICK1HZ}, 32'd0);
        @(posedge PCLK); #1;

        apb_wr(12'h008, 32'hFFFF_FFFF);
        apb_rd(12'h008, v); chk("trim_mask", v, 32'h0001_FFFF);
        apb_wr(12'h008, 32'h0);
        apb_wr(12'h010, 32'h1234_5678);
        apb_rd(12'h010, v); chk("unmapped_rd", v, 32'd0);
        apb_rd(12'h000, v); chk("unmapped_wr", v, 32'd24_999_999);
        apb.PSEL = 1'b1; apb.PWRITE = 1'b1; apb.PADDR = 10'h000; #1;
        chk("rd_gated_wr", apb.PRDATA, 32'd0);
        apb.PSEL = 1'b0; apb.PWRITE = 1'b0;
        @(posedge PCLK); #1;

        apb_wr(12'h000, 32'd3);
        apb_wr(12'h004, 32'd1);
        chk_seq("div3", 9, 4);
        apb_rd(12'h004, v); chk("pscr_run", v, 32'd1);
        @(posedge PCLK); #1;

        apb_wr(12'h004, 32'd0);
        chk("dis_clk", {31'd0, CLK1HZ}, 32'd0);
        apb_rd(12'h00C, v); chk("dis_cnt", v, 32'd0);
        repeat (3) @(posedge PCLK);
        #1;
        apb_rd(12'h00C, v); chk("idle_cnt", v, 32'd0);
        chk("idle_clk", {31'd0, CLK1HZ}, 32'd0);
        chk("idle_tick", {31'd0, TICK1HZ}, 32'd0);
        @(posedge PCLK); #1;

        apb_wr(12'h000, 32'd4);
        apb_wr(12'h004, 32'd1);
        chk_seq("div4", 11, 5);
        apb_wr(12'h004, 32'd0);
        apb_wr(12'h000, 32'd0);
        apb_wr(12'h004, 32'd1);
        chk_seq("div0", 5, 2);

        apb_wr(12'h004, 32'd0);
        apb_wr(12'h000, 32'd3);
        apb_wr(12'h008, 32'h0000_0002);
        apb_wr(12'h004, 32'd1);
        wait_tick(len); chk("trim_p0", len, 32'd4);
        wait_tick(len); chk("trim_p1", len, 32'd5);
        wait_tick(len); chk("trim_p2", len, 32'd4);
        wait_tick(len); chk("trim_p3", len, 32'd5);

        apb_wr(12'h004, 32'd0);
        apb_wr(12'h008, 32'h0001_0002);
        apb_wr(12'h004, 32'd1);
        wait_tick(len); chk("trimn_p0", len, 32'd4);
        wait_tick(len); chk("trimn_p1", len, 32'd3);
        wait_tick(len); chk("trimn_p2", len, 32'd4);
        wait_tick(len); chk("trimn_p3", len, 32'd3);

        apb_wr(12'h004, 32'd0);
        apb_wr(12'h008, 32'h0);
        apb_wr(12'h004, 32'd1);
        apb_wr(12'h000, 32'd9);
        apb_rd(12'h00C, v); chk("mid_cnt", v, 32'd2);
        wait_tick(len); chk("mid_rest", len, 32'd2);
        wait_tick(len); chk("mid_next", len, 32'd10);
        apb_wr(12'h004, 32'd1);
        apb_rd(12'h00C, v); chk("en_again", v, 32'd2);

        apb_wr(12'h004, 32'd0);
        apb_wr(12'h000, 32'd3);
        apb_wr(12'h004, 32'd1);
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        chk("pre_rst_clk", {31'd0, CLK1HZ}, 32'd1);
        PRESETn = 1'b0;
        #1;
        chk("arst_clk", {31'd0, CLK1HZ}, 32'd0);
        chk("arst_tick", {31'd0, TICK1HZ}, 32'd0);
        apb_rd(12'h00C, v); chk("arst_cnt", v, 32'd0);
        apb_rd(12'h004, v); chk("arst_pscr", v, 32'd0);
        apb_rd(12'h000, v); chk("arst_psdiv", v, 32'd24_999_999);
        @(negedge PCLK);
        PRESETn = 1'b1;
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge PCLK); #1;
            if (TICK1HZ) ticks++;
        end
        chk("post_rst_ticks", ticks, 32'd0);
        apb_wr(12'h000, 32'd3);
        apb_wr(12'h004, 32'd1);
        chk_seq("re_en", 5, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
